// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared execute/memory stage types, memory FSM states and access-size encodings
package pipeline_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] alu_res;
    logic [31:0] op3;
    logic [4:0]  rd;
    logic        w_rd;
    logic        link;
    logic        mem_r;
    logic        mem_w;
    logic [1:0]  mem_sz;
    logic        mem_sx;
    logic        io_r;
    logic        io_w;
    logic        bubble;
  } ex_out_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic        w_rd;
    logic [31:0] res;
    logic        bubble;
  } mem_out_t;
  typedef enum logic [1:0] {IDLE, REQ, DATA, IO} mem_state_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
endpackage

// File: rtl/load_fmt.sv
// load_fmt: selects the addressed byte/half lane of a bus word and zero/sign-extends it
//   rdata: raw bus word, addr: low address bits, sz: access size, sx: sign-extend, data: formatted result
module load_fmt
  import pipeline_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  sz,
  input  logic        sx,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = sz == SZ_WORD ? rdata :
           sz == SZ_HALF ? {{16{sx & h[15]}}, h} : {{24{sx & b[7]}}, b};
  end
endmodule

// File: rtl/stage_mem.sv
// stage_mem: pipeline memory stage driving a data bus and an io bus, with stall, timeout and fault
//   clk/rst_n: clock and async active-low reset; EX: execute result; out: writeback/forwarding
//   stall: freeze upstream; fault: pulse on timeout (or misalignment with STAGE_MEM_ALIGN_CHECK_EN)
//   dmem_*: data bus request/response; io_*: io bus request/response
module stage_mem
  import pipeline_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ex_out_t     EX,
  output mem_out_t    out,
  output logic        stall,
  output logic        fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [15:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic        io_ack,
  input  logic [31:0] io_rdata
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  ex_out_t        r;
  mem_state_t     state, nxt;
  logic [CW-1:0]  cnt;
  logic           rd_op, wr_op, io_rd, io_wr, mem_go, io_go, misal, tmo, unused_ok;
  logic [31:0]    ld_data;
  // a read flag wins over a write flag, so an illegal r+w encoding behaves as a read
  assign rd_op  = r.mem_r;
  assign wr_op  = r.mem_w & ~r.mem_r;
  assign io_rd  = r.io_r;
  assign io_wr  = r.io_w & ~r.io_r;
  assign mem_go = ~r.bubble & (r.mem_r | r.mem_w);
  assign io_go  = ~r.bubble & (r.io_r | r.io_w);
  assign tmo    = state != IDLE && cnt == CW'(WAIT_MAX);
  assign unused_ok = ^r.pc;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
  assign misal = (r.mem_sz == SZ_HALF && r.alu_res[0]) || (r.mem_sz == SZ_WORD && r.alu_res[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif
  load_fmt u_fmt (
    .rdata(dmem_rdata),
    .addr (r.alu_res[1:0]),
    .sz   (r.mem_sz),
    .sx   (r.mem_sx),
    .data (ld_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // the wait counter restarts on every state change, so each bus phase gets its own budget
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      r <= '0;
      r.bubble <= 1'b1;
    end else begin
      cnt <= (state != nxt || nxt == IDLE) ? '0 : cnt + 1'b1;
      if (!stall) r <= EX;
    end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = mem_go ? (misal ? IDLE : REQ) : io_go ? IO : IDLE;
      REQ:     nxt = dmem_gnt ? (rd_op ? DATA : IDLE) : tmo ? IDLE : REQ;
      DATA:    nxt = (dmem_rvalid || tmo) ? IDLE : DATA;
      IO:      nxt = (io_ack || tmo) ? IDLE : IO;
      default: nxt = IDLE;
    endcase
  end
  // stall follows the next state, so completion cycles already release upstream
  always_comb begin
    stall = nxt != IDLE;
    fault = tmo | (state == IDLE & mem_go & misal);
    dmem_req = state == REQ;
    io_req = state == IO;
    out.rd = r.rd;
    out.bubble = r.bubble;
    out.res = state == DATA ? ld_data : state == IO ? io_rdata : r.link ? r.nextpc : r.alu_res;
    out.w_rd = r.w_rd & ~r.bubble & (state == DATA ? dmem_rvalid :
                                     state == IO   ? io_ack & io_rd :
                                     state == REQ  ? 1'b0 : ~mem_go & ~io_go);
  end
  assign dmem_we    = wr_op;
  assign dmem_addr  = {r.alu_res[31:2], 2'b00};
  assign dmem_be    = r.mem_sz == SZ_WORD ? 4'hF :
                      r.mem_sz == SZ_HALF ? (r.alu_res[1] ? 4'b1100 : 4'b0011) :
                      4'b0001 << r.alu_res[1:0];
  assign dmem_wdata = r.op3;
  assign io_we      = io_wr;
  assign io_addr    = r.alu_res[15:0];
  assign io_wdata   = r.op3;
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed checks of stage_mem loads, stores, io timeout, reset abort and alignment
module tb_stage_mem;
  import pipeline_pkg::*;
  logic        clk = 0, rst_n = 1;
  ex_out_t     ex;
  mem_out_t    out;
  logic        stall, fault, dmem_req, dmem_we, io_req, io_we;
  logic [31:0] dmem_addr, dmem_wdata, io_wdata;
  logic [3:0]  dmem_be;
  logic [15:0] io_addr;
  logic        dmem_gnt = 0, dmem_rvalid = 0, io_ack = 0;
  logic [31:0] dmem_rdata = 0, io_rdata = 0;
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  stage_mem dut (
    .clk(clk), .rst_n(rst_n), .EX(ex), .out(out), .stall(stall), .fault(fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic ex_out_t bub();
    ex_out_t e = '0;
    e.bubble = 1'b1;
    return e;
  endfunction
  // kind = {mem_r, mem_w, io_r, io_w}
  function automatic ex_out_t op(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                                 input logic w, input logic [1:0] sz, input logic sx, input logic [3:0] kind);
    ex_out_t e = '0;
    e.alu_res = a;
    e.op3 = d;
    e.rd = rd;
    e.w_rd = w;
    e.mem_sz = sz;
    e.mem_sx = sx;
    {e.mem_r, e.mem_w, e.io_r, e.io_w} = kind;
    return e;
  endfunction
  initial begin
    int n_st, w;
    ex = bub();
    #1 rst_n = 0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_fault", fault, 0);
    check("rst_dreq", dmem_req, 0);
    check("rst_ioreq", io_req, 0);
    check("rst_wrd", out.w_rd, 0);
    check("rst_bubble", out.bubble, 1);
    tick;
    rst_n = 1;
    // plain ALU result and link result
    ex = op(32'h1234, 0, 5'd5, 1, SZ_WORD, 0, 4'b0000);
    ex.nextpc = 32'h44;
    tick;
    check("alu_res", out.res, 32'h1234);
    check("alu_wrd", out.w_rd, 1);
    check("alu_rd", out.rd, 5);
    check("alu_stall", stall, 0);
    check("alu_bubble", out.bubble, 0);
    ex.link = 1;
    tick;
    check("link_res", out.res, 32'h44);
    ex = bub();
    tick;
    check("bub_wrd", out.w_rd, 0);
    check("bub_bubble", out.bubble, 1);
    check("bub_dreq", dmem_req, 0);
    // signed byte load at 0x103
    ex = op(32'h103, 0, 5'd7, 1, SZ_BYTE, 1, 4'b1000);
    tick;
    ex = bub();
    check("lb_idle_stall", stall, 1);
    check("lb_idle_wrd", out.w_rd, 0);
    tick;
    check("lb_req", dmem_req, 1);
    check("lb_addr", dmem_addr, 32'h100);
    check("lb_be", dmem_be, 4'b1000);
    check("lb_we", dmem_we, 0);
    dmem_gnt = 1;
    #1 check("lb_gnt_stall", stall, 1);
    tick;
    dmem_gnt = 0;
    check("lb_data_stall", stall, 1);
    check("lb_data_wrd", out.w_rd, 0);
    check("lb_data_req", dmem_req, 0);
    dmem_rvalid = 1;
    dmem_rdata = 32'h80FF_0000;
    #1;
    check("lb_res", out.res, 32'hFFFF_FF80);
    check("lb_wrd", out.w_rd, 1);
    check("lb_rd", out.rd, 7);
    check("lb_stall", stall, 0);
    tick;
    dmem_rvalid = 0;
    // half store at 0x202 with grant held off for three cycles
    ex = op(32'h202, 32'hBEEF_BEEF, 5'd0, 0, SZ_HALF, 0, 4'b0100);
    tick;
    ex = bub();
    check("sh_idle_stall", stall, 1);
    tick;
    for (int c = 0; c < 3; c++) begin
      check("sh_req", dmem_req, 1);
      check("sh_addr", dmem_addr, 32'h200);
      check("sh_be", dmem_be, 4'b1100);
      check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
      check("sh_we", dmem_we, 1);
      check("sh_stall", stall, 1);
      tick;
    end
    dmem_gnt = 1;
    #1 check("sh_gnt_stall", stall, 0);
    check("sh_gnt_req", dmem_req, 1);
    tick;
    dmem_gnt = 0;
    check("sh_done_req", dmem_req, 0);
    // unsigned half load with illegal r+w encoding behaves as a read
    ex = op(32'h202, 0, 5'd3, 1, SZ_HALF, 0, 4'b1100);
    tick;
    ex = bub();
    tick;
    check("lhu_we", dmem_we, 0);
    check("lhu_be", dmem_be, 4'b1100);
    dmem_gnt = 1;
    tick;
    dmem_gnt = 0;
    dmem_rvalid = 1;
    dmem_rdata = 32'h8001_0000;
    #1 check("lhu_res", out.res, 32'h0000_8001);
    check("lhu_wrd", out.w_rd, 1);
    tick;
    dmem_rvalid = 0;
    // word load (sx ignored): gnt in cycle 1, rvalid in cycle 4
    ex = op(32'h300, 0, 5'd9, 1, SZ_WORD, 1, 4'b1000);
    tick;
    ex = bub();
    n_st = 0;
    for (int c = 0; c < 8; c++) begin
      dmem_gnt = (c == 1);
      dmem_rvalid = (c == 4);
      dmem_rdata = 32'hCAFE_F00D;
      #1;
      if (stall) n_st++;
      if (c < 4) check("lw_wrd_low", out.w_rd, 0);
      if (c == 4) begin
        check("lw_wrd", out.w_rd, 1);
        check("lw_res", out.res, 32'hCAFE_F00D);
      end
      tick;
    end
    dmem_gnt = 0;
    dmem_rvalid = 0;
    check("lw_stall_cycles", n_st, 4);
    // io write that is never acknowledged
    ex = op(32'h0001_0010, 32'h55, 5'd4, 1, SZ_WORD, 0, 4'b0001);
    tick;
    ex = bub();
    check("io_idle_stall", stall, 1);
    tick;
    check("io_req", io_req, 1);
    check("io_addr", io_addr, 16'h0010);
    check("io_we", io_we, 1);
    check("io_wdata", io_wdata, 32'h55);
    w = 0;
    while (!fault && w < 400) begin
      w++;
      tick;
    end
    check("io_wait_cycles", w, 255);
    check("io_tmo_stall", stall, 0);
    check("io_tmo_wrd", out.w_rd, 0);
    tick;
    check("io_fault_pulse", fault, 0);
    check("io_req_off", io_req, 0);
    // reset while a load waits for data; late rvalid must be ignored
    ex = op(32'h400, 0, 5'd11, 1, SZ_WORD, 0, 4'b1000);
    tick;
    ex = bub();
    tick;
    dmem_gnt = 1;
    tick;
    dmem_gnt = 0;
    check("rdata_stall", stall, 1);
    rst_n = 0;
    #1;
    check("abort_stall", stall, 0);
    check("abort_wrd", out.w_rd, 0);
    check("abort_bubble", out.bubble, 1);
    check("abort_dreq", dmem_req, 0);
    tick;
    rst_n = 1;
    dmem_rvalid = 1;
    dmem_rdata = 32'h1357_9BDF;
    #1;
    check("late_wrd", out.w_rd, 0);
    check("late_stall", stall, 0);
    check("late_fault", fault, 0);
    tick;
    dmem_rvalid = 0;
    // misaligned word load at 0x102
    ex = op(32'h102, 0, 5'd2, 1, SZ_WORD, 0, 4'b1000);
    tick;
    ex = bub();
`ifdef STAGE_MEM_ALIGN_CHECK_EN
    check("mis_fault", fault, 1);
    check("mis_stall", stall, 0);
    check("mis_wrd", out.w_rd, 0);
    tick;
    check("mis_dreq", dmem_req, 0);
    check("mis_fault_pulse", fault, 0);
`else
    check("mis_fault", fault, 0);
    check("mis_stall", stall, 1);
    tick;
    check("mis_dreq", dmem_req, 1);
    check("mis_addr", dmem_addr, 32'h100);
    check("mis_be", dmem_be, 4'hF);
    dmem_gnt = 1;
    tick;
    dmem_gnt = 0;
    dmem_rvalid = 1;
    dmem_rdata = 32'h1122_3344;
    #1 check("mis_res", out.res, 32'h1122_3344);
    tick;
    dmem_rvalid = 0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 255, meaning the maximum number of cycles spent waiting in a bus state before a timeout fault.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port EX, input, ex_out_t: execute-stage result (pc, nextpc, alu_res, op3, rd, w_rd, link, mem_r/w, mem_sz, mem_sx, io_r/w, bubble).
REQ-005 SHALL have port out, output, mem_out_t: rd, w_rd, res, bubble; also the forwarding source for execute.
REQ-006 SHALL have port stall, output, 1 bit: freeze the upstream stages and their pipeline registers.
REQ-007 SHALL have port fault, output, 1 bit: one-cycle pulse on misaligned access or bus timeout.
REQ-008 SHALL have data-bus ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_be out 4, dmem_wdata out 32, dmem_gnt in 1, dmem_rvalid in 1, dmem_rdata in 32.
REQ-009 SHALL have io-bus ports: io_req out 1, io_we out 1, io_addr out 16, io_wdata out 32, io_ack in 1, io_rdata in 32.

Function
REQ-010 SHALL register all EX fields on each clk edge while stall=0, and hold them while stall=1.
REQ-011 SHALL compute non-memory result combinationally as res = link ? nextpc : alu_res, with zero added latency.
REQ-012 SHALL use FSM states IDLE, REQ, DATA, IO:
- IDLE->REQ on a registered mem_r/mem_w with bubble=0.
- IDLE->IO on io_r/io_w.
- REQ->DATA on dmem_gnt with a read.
- REQ->IDLE on dmem_gnt with a write.
- DATA->IDLE on dmem_rvalid.
- IO->IDLE on io_ack.
REQ-013 SHALL assert stall whenever the next state is not IDLE, and in REQ, DATA and IO; a store completes with one stall cycle minimum and a load with two.
REQ-014 SHALL hold dmem_req/io_req high and all request fields constant until dmem_gnt or io_ack is sampled high.
REQ-015 SHALL drive dmem_addr = {alu_res[31:2],2'b00}.
REQ-016 SHALL drive dmem_be as 1 bit at alu_res[1:0] for byte, 2 bits at alu_res[1] for half, and 4'hF for word.
REQ-017 SHALL drive dmem_wdata = op3 unchanged, since execute has already replicated the lanes.
REQ-018 SHALL extract loads from the addressed lane and zero- or sign-extend them per mem_sx; mem_sz=2 SHALL ignore mem_sx.
REQ-019 SHALL drive out.res = formatted load data and out.w_rd = w_rd in the cycle dmem_rvalid=1, and drop stall in that same cycle.
REQ-020 SHALL keep out.w_rd = 0 while a load is outstanding, so no stale forwarding occurs.
REQ-021 SHALL take io_addr = alu_res[15:0]; io_r returns io_rdata as a full word.
REQ-022 SHALL keep a wait counter that clears on entering REQ, DATA or IO; on reaching WAIT_MAX it SHALL pulse fault, return to IDLE, suppress w_rd and release stall.
REQ-023 SHALL make out.bubble follow the registered bubble; a bubble SHALL never issue a request or write rd.
REQ-024 SHALL give mem_r and io_r precedence over mem_w/io_w if both are set (illegal encoding), and treat the access as a read.

Reset
REQ-025 SHALL on rst_n=0 immediately set: state IDLE, stall 0, fault 0, dmem_req 0, io_req 0, out.w_rd 0, out.bubble 1, registered bubble 1, counter 0.
REQ-026 SHALL abandon any outstanding transaction on reset assertion; a dmem_rvalid arriving after reset SHALL be ignored.

Configuration
REQ-027 SHALL support the macro STAGE_MEM_ALIGN_CHECK_EN.
- Defined: half at odd address or word with alu_res[1:0]!=0 issues no request, pulses fault, suppresses w_rd, no stall.
- Undefined: address bits are used as given and no alignment fault exists (fault only on timeout).

Structure
REQ-028 SHALL place ex_out_t, mem_out_t, the FSM state enum and mem_sz encodings (0 byte, 1 half, 2 word) in pipeline_pkg.
REQ-029 SHALL implement load lane select and extension in sub-module load_fmt (inputs rdata, addr[1:0], sz, sx; output 32-bit word).

Verification
REQ-030 Bench SHALL cover:
- Byte load sx=1, addr 0x103, rdata 0x80FF_0000 -> res 0xFFFF_FF80, w_rd high in rvalid cycle.
- Half store op3 0xBEEF_BEEF, addr 0x202 -> be 4'b1100, addr 0x200, gnt delayed 3 cycles with request stable throughout.
- Word load with gnt on cycle 1, rvalid on cycle 4 -> stall high for exactly 4 cycles, w_rd low until rvalid.
- IO write addr 0x0010 with io_ack never arriving -> fault pulse after 255 wait cycles, stall released, no rd write.
- rst_n low while in DATA, late rvalid -> state IDLE, w_rd 0, rvalid ignored.
- With macro defined, word load at 0x102 -> no dmem_req, fault pulse; without macro, request addr 0x100.
